// File: rtl/alu2_arbiter_if.sv
// Requester, ALU and response signals of the ALU2 arbiter.
// The slave side is the arbiter; the master side is its environment.
interface alu2_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] alu_opdec;
  logic [3:0]  alu_rl;
  logic [3:0]  alu_rh;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_rl, alu_rh, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_opdec,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_rl, alu_rh, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_opdec,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu2_arbiter.sv
// Two-requester round-robin arbiter and sequencer
// for the shared 8-bit ALU2 datapath.
module alu2_arbiter #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_OPS       = 9
) (
  input logic           clk,
  input logic           reset_n,
  alu2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES);
  localparam logic [4:0] OP_LIM   = 5'(NUM_OPS);

  state_e     state_d, state_q;
  logic       ptr_d, ptr_q;
  logic       id_d, id_q;
  logic       err_d, err_q;
  logic [3:0] op_d, op_q;
  logic [3:0] cnt_d, cnt_q;
  logic [7:0] a_d, a_q;
  logic [7:0] b_d, b_q;
  logic [7:0] res_d, res_q;
  logic       g0, g1;
  logic       legal;

  assign legal = {1'b0, op_q} < OP_LIM;

  // Grant in IDLE only; the pointer breaks ties, never while in reset.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state_q == IDLE && reset_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        g0 = !ptr_q;
        g1 = ptr_q;
      end else begin
        g0 = bus.req0_valid;
        g1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_opdec  = (state_q == EXEC && legal) ?
                          (16'd1 << op_q) : 16'd0;
  assign bus.rsp_valid  = state_q == RESP;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_err    = err_q;

  // Next-state: accept, settle, capture, then hold the response.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (g0 || g1) begin
          id_d    = g1;
          op_d    = g1 ? bus.req1_op : bus.req0_op;
          a_d     = g1 ? bus.req1_a : bus.req0_a;
          b_d     = g1 ? bus.req1_b : bus.req0_b;
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_d   = legal ? {bus.alu_rh, bus.alu_rl} : 8'h00;
          err_d   = !legal;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          ptr_d   = !id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= 4'd0;
      cnt_q   <= 4'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      res_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      err_q   <= err_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_alu2_arbiter.sv
// Bench for alu2_arbiter: directed steps plus random commands
// checked against an opcode-level reference model.
module tb_alu2_arbiter;

  localparam int NUM_OPS = 9;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst4_n;
  int   ncmp = 0;
  int   nfail = 0;
  bit   model_ptr;

  alu2_arbiter_if b1();
  alu2_arbiter_if b4();

  alu2_arbiter #(.SETTLE_CYCLES(1), .NUM_OPS(NUM_OPS)) u1 (
    .clk(clk), .reset_n(rst1_n), .bus(b1)
  );
  alu2_arbiter #(.SETTLE_CYCLES(4), .NUM_OPS(NUM_OPS)) u4 (
    .clk(clk), .reset_n(rst4_n), .bus(b4)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(input int op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      0: for (int i = 0; i < 8; i++) r[i] = a[7-i];
      1: r = 8'((a << 4) | 8'h0F);
      2: r = {~b[7:4], b[3:0]};
      3: r = (a < b) ? a : b;
      4: r = 8'(a + b + 8'd4);
      5: r = 8'(a + 8'd3);
      6: r = (b & 8'h55) | (a & 8'hAA);
      7: r = ~(a ^ b);
      8: r = {b[2:0], b[7:3]};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Behavioural ALU: garbage when nothing is selected.
  function automatic logic [7:0] alu_model(input logic [15:0] dec,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [7:0] r;
    r = 8'h5A;
    for (int i = 0; i < 16; i++)
      if (dec[i]) r = ref_op(i, a, b);
    return r;
  endfunction

  assign {b1.alu_rh, b1.alu_rl} =
    alu_model(b1.alu_opdec, b1.alu_a, b1.alu_b);
  assign {b4.alu_rh, b4.alu_rl} =
    alu_model(b4.alu_opdec, b4.alu_a, b4.alu_b);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit id, input logic v,
                         input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      b1.req1_valid = v; b1.req1_op = op;
      b1.req1_a = a; b1.req1_b = b;
    end else begin
      b1.req0_valid = v; b1.req0_op = op;
      b1.req0_a = a; b1.req0_b = b;
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? b1.req1_ready : b1.req0_ready;
  endfunction

  // One lone command on u1, starting and ending #1 after an edge in IDLE.
  task automatic send(input bit id, input logic [3:0] op,
                      input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  er;
    logic [15:0] ed;
    logic [15:0] one;
    int n;
    one = 16'd1;
    er = (op < NUM_OPS) ? ref_op(int'(op), a, b) : 8'h00;
    ed = (op < NUM_OPS) ? (one << op) : 16'h0000;
    b1.rsp_ready = 1'b1;
    set_req(id, 1'b1, op, a, b);
    #1;
    chk("grant", {30'd0, rdy(id), rdy(!id)}, 2'b10);
    @(posedge clk); #1;
    set_req(id, 1'b0, 4'($urandom), 8'($urandom), 8'($urandom));
    n = 0;
    while (!b1.rsp_valid && n < 20) begin
      chk("opdec", b1.alu_opdec, ed);
      chk("alu_a", b1.alu_a, a);
      chk("alu_b", b1.alu_b, b);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 1);
    chk("rsp_id", b1.rsp_id, id);
    chk("rsp_result", b1.rsp_result, er);
    chk("rsp_err", b1.rsp_err, op >= NUM_OPS);
    model_ptr = !id;
    @(posedge clk); #1;
    chk("rsp_drop", b1.rsp_valid, 0);
  endtask

  initial begin : main
    int cyc;
    int last;
    int got;
    int n;
    bit expid;

    rst1_n = 1'b0;
    rst4_n = 1'b0;
    b1.req0_valid = 1'b1; b1.req0_op = 4'd4;
    b1.req0_a = 8'h11; b1.req0_b = 8'h22;
    b1.req1_valid = 1'b0; b1.req1_op = 4'd0;
    b1.req1_a = 8'h00; b1.req1_b = 8'h00;
    b1.rsp_ready = 1'b1;
    b4.req0_valid = 1'b0; b4.req0_op = 4'd0;
    b4.req0_a = 8'h00; b4.req0_b = 8'h00;
    b4.req1_valid = 1'b0; b4.req1_op = 4'd0;
    b4.req1_a = 8'h00; b4.req1_b = 8'h00;
    b4.rsp_ready = 1'b1;
    model_ptr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", b1.req0_ready, 0);
    chk("rst_ready1", b1.req1_ready, 0);
    chk("rst_alu_a", b1.alu_a, 0);
    chk("rst_alu_b", b1.alu_b, 0);
    chk("rst_opdec", b1.alu_opdec, 0);
    chk("rst_valid", b1.rsp_valid, 0);
    chk("rst_id", b1.rsp_id, 0);
    chk("rst_result", b1.rsp_result, 0);
    chk("rst_err", b1.rsp_err, 0);
    b1.req0_valid = 1'b0;
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    @(posedge clk); #1;

    send(1'b0, 4'd4, 8'h10, 8'h20);
    send(1'b1, 4'd0, 8'h01, 8'h00);
    send(1'b1, 4'd3, 8'h50, 8'h30);
    send(1'b1, 4'd8, 8'h00, 8'h01);
    send(1'b1, 4'd1, 8'h05, 8'h00);

    // Contention: both held, responses alternate every 3 cycles.
    set_req(1'b0, 1'b1, 4'd7, 8'h3C, 8'h0F);
    set_req(1'b1, 1'b1, 4'd5, 8'h10, 8'h00);
    expid = model_ptr;
    last = -1; cyc = 0; got = 0;
    while (got < 4 && cyc < 40) begin
      if (b1.rsp_valid) begin
        chk("cont_id", b1.rsp_id, expid);
        chk("cont_res", b1.rsp_result,
            expid ? ref_op(5, 8'h10, 8'h00)
                  : ref_op(7, 8'h3C, 8'h0F));
        if (last >= 0) chk("cont_gap", cyc - last, 3);
        last = cyc;
        expid = !expid;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("cont_count", got, 4);
    set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
    model_ptr = expid;

    send(1'b0, 4'hA, 8'h77, 8'h11);

    // Backpressure: response held for 5 cycles, no grants meanwhile.
    b1.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 4'd2, 8'h00, 8'hA5);
    #1;
    chk("bp_grant", b1.req0_ready, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
    n = 0;
    while (!b1.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid", b1.rsp_valid, 1);
    b1.req1_valid = 1'b1;
    b1.req1_op = 4'd6;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold", b1.rsp_valid, 1);
      chk("bp_res", b1.rsp_result, ref_op(2, 8'h00, 8'hA5));
      chk("bp_id", b1.rsp_id, 0);
      chk("bp_rdy", {b1.req0_ready, b1.req1_ready}, 2'b00);
      @(posedge clk); #1;
    end
    b1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", b1.rsp_valid, 0);
    chk("bp_idle_rdy", b1.req1_ready, 1);
    b1.req1_valid = 1'b0;
    model_ptr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("drop_noexec", b1.alu_opdec, 0);
      chk("drop_norsp", b1.rsp_valid, 0);
    end

    // Random lone commands, legal and illegal opcodes.
    for (int k = 0; k < 30; k++)
      send(1'($urandom), 4'($urandom_range(0, 15)),
           8'($urandom), 8'($urandom));

    // Reset mid-EXEC on the 4-cycle instance.
    b4.req0_valid = 1'b1; b4.req0_op = 4'd5;
    b4.req0_a = 8'h20; b4.req0_b = 8'h00;
    @(posedge clk); #1;
    b4.req0_valid = 1'b0;
    n = 0;
    while (!b4.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s4_latency", n, 4);
    chk("s4_result", b4.rsp_result, ref_op(5, 8'h20, 8'h00));
    @(posedge clk); #1;
    b4.req0_valid = 1'b1; b4.req0_op = 4'd0; b4.req0_a = 8'h0F;
    b4.req1_valid = 1'b1; b4.req1_op = 4'd1; b4.req1_a = 8'h33;
    #1;
    chk("s4_ptr_grant", {b4.req0_ready, b4.req1_ready}, 2'b01);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("s4_exec2", b4.alu_opdec, 16'h0002);
    rst4_n = 1'b0;
    #1;
    chk("mr_opdec", b4.alu_opdec, 0);
    chk("mr_alu_a", b4.alu_a, 0);
    chk("mr_alu_b", b4.alu_b, 0);
    chk("mr_valid", b4.rsp_valid, 0);
    chk("mr_id", b4.rsp_id, 0);
    chk("mr_result", b4.rsp_result, 0);
    chk("mr_err", b4.rsp_err, 0);
    chk("mr_rdy", {b4.req0_ready, b4.req1_ready}, 2'b00);
    b4.req0_valid = 1'b0;
    b4.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst4_n = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (b4.rsp_valid) got++;
    end
    chk("mr_no_rsp", got, 0);
    b4.req0_valid = 1'b1;
    b4.req1_valid = 1'b1;
    #1;
    chk("mr_next_grant", {b4.req0_ready, b4.req1_ready}, 2'b10);
    b4.req0_valid = 1'b0;
    b4.req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
